// File: rtl/tdec_wrap_rm_if.sv
// tdec_wrap_rm_if -- memory-side bus of the rate-matching packer.
//
// Groups the source RAM read port and the destination RAM write port.
//   master : the packer (drives read requests and write strobes)
//   slave  : the memories (drive read ack and read data)
//
// Signals
//   siram_rd_req      read request, held until acknowledged
//   siram_rd_req_ack  same-cycle ack; data valid the cycle after
//   siram_rd_addr     source word address (11 bits)
//   siram_rd_data     {d3,d2,d1,d0}, d0 in [4:0]
//   dwram_wr_req      one-cycle write strobe
//   dwram_wr_addr     destination word address (16 bits)
//   dwram_wr_data     slot0=[19:15] .. slot3=[4:0]
//   dwram_wr_be       lane enables, be[3]=slot0 .. be[0]=slot3
interface tdec_wrap_rm_if;
  logic        siram_rd_req;
  logic        siram_rd_req_ack;
  logic [10:0] siram_rd_addr;
  logic [19:0] siram_rd_data;
  logic        dwram_wr_req;
  logic [15:0] dwram_wr_addr;
  logic [19:0] dwram_wr_data;
  logic [3:0]  dwram_wr_be;

  modport master (
    output siram_rd_req,
    output siram_rd_addr,
    input  siram_rd_req_ack,
    input  siram_rd_data,
    output dwram_wr_req,
    output dwram_wr_addr,
    output dwram_wr_data,
    output dwram_wr_be
  );

  modport slave (
    input  siram_rd_req,
    input  siram_rd_addr,
    output siram_rd_req_ack,
    output siram_rd_data,
    input  dwram_wr_req,
    input  dwram_wr_addr,
    input  dwram_wr_data,
    input  dwram_wr_be
  );
endinterface

// File: rtl/tdec_wrap_rm.sv
// tdec_wrap_rm -- rate-matching packer for the turbo wrapper transmit path.
//
// Reads a code block of 5-bit symbols (four per source word), appends four
// tail symbols, drops punctured positions with the e-algorithm and packs the
// survivors MSB-slot first into the destination RAM starting at an arbitrary
// symbol offset. Partial trailing words are written with their lane enables
// and the next block continues in the same word.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   init                sync clear; aborts and loads base_addr into the write pointer
//   start               one-cycle pulse, begins one block (ignored while busy)
//   done                one-cycle pulse after the last write of the block
//   codeblk_size_m1     block length minus 1 (tails excluded)
//   base_addr           destination symbol address, [17:2] word, [1:0] slot
//   rm_repeat           1 = no puncturing
//   rm_ei/rm_em/rm_ep   e-algorithm e_ini, e_minus, e_plus
//   tail_0..tail_3      tail symbols, stable from start to done
//   rm_out_len          symbols emitted in the last block, valid at done
//   bus                 source read / destination write port (master side)
//
// Build option
//   TDEC_RM_CB_REBASE_EN  when defined, every start reloads the write pointer
//                         from base_addr; otherwise only init does, and
//                         consecutive blocks pack contiguously.
module tdec_wrap_rm (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic                  start,
  output logic                  done,
  input  logic [12:0]           codeblk_size_m1,
  input  logic [17:0]           base_addr,
  input  logic                  rm_repeat,
  input  logic [16:0]           rm_ei,
  input  logic [16:0]           rm_em,
  input  logic [16:0]           rm_ep,
  input  logic [4:0]            tail_0,
  input  logic [4:0]            tail_1,
  input  logic [4:0]            tail_2,
  input  logic [4:0]            tail_3,
  output logic [13:0]           rm_out_len,
  tdec_wrap_rm_if.master        bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PROC,
    S_FLUSH
  } state_t;

  state_t      state_q, state_d;
  logic [13:0] cnt_q, cnt_d;
  logic [17:0] e_q, e_d;
  logic        rd_req_q, rd_req_d;
  logic [10:0] rd_addr_q, rd_addr_d;
  logic [19:0] cache_q, cache_d;
  logic [15:0] wword_q, wword_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [19:0] acc_q, acc_d;
  logic [3:0]  be_acc_q, be_acc_d;
  logic        wr_req_q, wr_req_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [19:0] wr_data_q, wr_data_d;
  logic [3:0]  wr_be_q, wr_be_d;
  logic        done_q, done_d;
  logic [13:0] out_len_q, out_len_d;

  logic [13:0] last_data;
  logic        is_tail;
  logic        last_sym;
  logic [1:0]  tail_idx;
  logic [4:0]  cache_sym;
  logic [4:0]  tail_sym;
  logic [4:0]  sym;
  logic        punc;
  logic [19:0] acc_new;
  logic [3:0]  be_new;

  // Symbol selection for the current count
  always_comb begin
    last_data = {1'b0, codeblk_size_m1};
    is_tail   = cnt_q > last_data;
    last_sym  = cnt_q == (last_data + 14'd4);
    // (cnt - size_m1 - 1) mod 4 only needs the low bits
    tail_idx  = cnt_q[1:0] - codeblk_size_m1[1:0] - 2'd1;

    cache_sym = '0;
    case (cnt_q[1:0])
      2'd0:    cache_sym = cache_q[4:0];
      2'd1:    cache_sym = cache_q[9:5];
      2'd2:    cache_sym = cache_q[14:10];
      default: cache_sym = cache_q[19:15];
    endcase

    tail_sym = '0;
    case (tail_idx)
      2'd0:    tail_sym = tail_0;
      2'd1:    tail_sym = tail_1;
      2'd2:    tail_sym = tail_2;
      default: tail_sym = tail_3;
    endcase

    sym  = is_tail ? tail_sym : cache_sym;
    punc = ~rm_repeat & e_q[17];

    acc_new = acc_q;
    case (ptr_q)
      2'd0:    acc_new[19:15] = sym;
      2'd1:    acc_new[14:10] = sym;
      2'd2:    acc_new[9:5]   = sym;
      default: acc_new[4:0]   = sym;
    endcase
    be_new = be_acc_q | (4'b1000 >> ptr_q);
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    e_d       = e_q;
    rd_req_d  = rd_req_q;
    rd_addr_d = rd_addr_q;
    cache_d   = cache_q;
    wword_d   = wword_q;
    ptr_d     = ptr_q;
    acc_d     = acc_q;
    be_acc_d  = be_acc_q;
    out_len_d = out_len_q;
    wr_req_d  = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    wr_be_d   = '0;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d     = '0;
          e_d       = {1'b0, rm_ei} - {1'b0, rm_em};
          rd_addr_d = '0;
          out_len_d = '0;
          rd_req_d  = 1'b1;
          state_d   = S_FETCH;
`ifdef TDEC_RM_CB_REBASE_EN
          wword_d   = base_addr[17:2];
          ptr_d     = base_addr[1:0];
          acc_d     = '0;
          be_acc_d  = '0;
`endif
        end
      end

      S_FETCH: begin
        if (bus.siram_rd_req_ack) begin
          rd_req_d  = 1'b0;
          rd_addr_d = rd_addr_q + 11'd1;
          state_d   = S_WAIT;
        end
      end

      S_WAIT: begin
        cache_d = bus.siram_rd_data;
        state_d = S_PROC;
      end

      S_PROC: begin
        if (!rm_repeat) begin
          e_d = punc ? (e_q + {1'b0, rm_ep} - {1'b0, rm_em})
                     : (e_q - {1'b0, rm_em});
        end
        if (!punc) begin
          out_len_d = out_len_q + 14'd1;
          ptr_d     = ptr_q + 2'd1;
          if (ptr_q == 2'd3) begin
            wr_req_d  = 1'b1;
            wr_addr_d = wword_q;
            wr_data_d = acc_new;
            wr_be_d   = be_new;
            wword_d   = wword_q + 16'd1;
            acc_d     = '0;
            be_acc_d  = '0;
          end else begin
            acc_d     = acc_new;
            be_acc_d  = be_new;
          end
        end
        cnt_d = cnt_q + 14'd1;
        if (last_sym) begin
          state_d = S_FLUSH;
        end else if ((cnt_q[1:0] == 2'd3) && (cnt_q < last_data)) begin
          rd_req_d = 1'b1;
          state_d  = S_FETCH;
        end
      end

      S_FLUSH: begin
        // Pending lanes, not ptr, decide the flush: ptr may be non-zero
        // from an earlier block while nothing new was packed in this one.
        // A flush write holds FLUSH one more cycle so done follows it.
        if (be_acc_q != 4'd0) begin
          wr_req_d  = 1'b1;
          wr_addr_d = wword_q;
          wr_data_d = acc_q;
          wr_be_d   = be_acc_q;
          acc_d     = '0;
          be_acc_d  = '0;
        end else begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (init) begin
      state_d   = S_IDLE;
      rd_req_d  = 1'b0;
      rd_addr_d = '0;
      out_len_d = '0;
      wr_req_d  = 1'b0;
      wr_addr_d = '0;
      wr_data_d = '0;
      wr_be_d   = '0;
      done_d    = 1'b0;
      wword_d   = base_addr[17:2];
      ptr_d     = base_addr[1:0];
      acc_d     = '0;
      be_acc_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      e_q       <= '0;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      cache_q   <= '0;
      wword_q   <= '0;
      ptr_q     <= '0;
      acc_q     <= '0;
      be_acc_q  <= '0;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_be_q   <= '0;
      done_q    <= 1'b0;
      out_len_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      e_q       <= e_d;
      rd_req_q  <= rd_req_d;
      rd_addr_q <= rd_addr_d;
      cache_q   <= cache_d;
      wword_q   <= wword_d;
      ptr_q     <= ptr_d;
      acc_q     <= acc_d;
      be_acc_q  <= be_acc_d;
      wr_req_q  <= wr_req_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_be_q   <= wr_be_d;
      done_q    <= done_d;
      out_len_q <= out_len_d;
    end
  end

  assign done              = done_q;
  assign rm_out_len        = out_len_q;
  assign bus.siram_rd_req  = rd_req_q;
  assign bus.siram_rd_addr = rd_addr_q;
  assign bus.dwram_wr_req  = wr_req_q;
  assign bus.dwram_wr_addr = wr_addr_q;
  assign bus.dwram_wr_data = wr_data_q;
  assign bus.dwram_wr_be   = wr_be_q;

endmodule

// File: tb/tb_tdec_wrap_rm.sv
// tb_tdec_wrap_rm -- self-checking bench for the rate-matching packer.
// A reference model pushes expected destination writes into a queue when a
// block is launched; a write monitor pops and compares every DUT write.
module tb_tdec_wrap_rm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init = 1'b0;
  logic        start = 1'b0;
  logic        done;
  logic [12:0] codeblk_size_m1 = '0;
  logic [17:0] base_addr = '0;
  logic        rm_repeat = 1'b0;
  logic [16:0] rm_ei = '0;
  logic [16:0] rm_em = '0;
  logic [16:0] rm_ep = '0;
  logic [4:0]  tail_0 = 5'h1C;
  logic [4:0]  tail_1 = 5'h1D;
  logic [4:0]  tail_2 = 5'h1E;
  logic [4:0]  tail_3 = 5'h1F;
  logic [13:0] rm_out_len;

  tdec_wrap_rm_if bus ();

  tdec_wrap_rm dut (
    .clk             (clk),
    .rst             (rst),
    .init            (init),
    .start           (start),
    .done            (done),
    .codeblk_size_m1 (codeblk_size_m1),
    .base_addr       (base_addr),
    .rm_repeat       (rm_repeat),
    .rm_ei           (rm_ei),
    .rm_em           (rm_em),
    .rm_ep           (rm_ep),
    .tail_0          (tail_0),
    .tail_1          (tail_1),
    .tail_2          (tail_2),
    .tail_3          (tail_3),
    .rm_out_len      (rm_out_len),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int ack_delay = 0;
  int req_hi_cycles = 0;

  logic [4:0]  sym [0:8199];
  logic [39:0] exp_q [$];
  logic [39:0] wr_log [$];
  logic [15:0] m_word = '0;
  int          m_ptr = 0;

  // Source RAM responder: ack after ack_delay waiting cycles, data next cycle
  initial begin
    int wait_cnt;
    int la;
    wait_cnt = 0;
    la = 0;
    bus.siram_rd_req_ack = 1'b0;
    bus.siram_rd_data = '0;
    forever begin
      @(negedge clk);
      if (bus.siram_rd_req_ack) begin
        bus.siram_rd_req_ack = 1'b0;
        bus.siram_rd_data = {sym[4*la+3], sym[4*la+2], sym[4*la+1], sym[4*la]};
      end else if (bus.siram_rd_req) begin
        req_hi_cycles++;
        if (wait_cnt >= ack_delay) begin
          bus.siram_rd_req_ack = 1'b1;
          la = int'(bus.siram_rd_addr);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Destination write monitor / scoreboard
  initial begin
    logic [39:0] got;
    logic [39:0] exp;
    forever begin
      @(negedge clk);
      if (!rst && bus.dwram_wr_req) begin
        got = {bus.dwram_wr_addr, bus.dwram_wr_data, bus.dwram_wr_be};
        wr_log.push_back(got);
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: got addr=%h data=%h be=%b, expected no write",
                   got[39:24], got[23:4], got[3:0]);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            n_fail++;
            $display("FAIL write_data: got addr=%h data=%h be=%b, expected addr=%h data=%h be=%b",
                     got[39:24], got[23:4], got[3:0], exp[39:24], exp[23:4], exp[3:0]);
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic model_block(output int exp_len);
    logic [17:0] e;
    logic [19:0] d;
    logic [3:0]  be;
    logic [4:0]  s;
    bit          punc;
    int          n;
    e = {1'b0, rm_ei} - {1'b0, rm_em};
    d = '0;
    be = '0;
    exp_len = 0;
`ifdef TDEC_RM_CB_REBASE_EN
    m_word = base_addr[17:2];
    m_ptr = int'(base_addr[1:0]);
`endif
    n = int'(codeblk_size_m1) + 5;
    for (int i = 0; i < n; i++) begin
      if (i <= int'(codeblk_size_m1)) s = sym[i];
      else begin
        case (i - int'(codeblk_size_m1) - 1)
          0: s = tail_0;
          1: s = tail_1;
          2: s = tail_2;
          default: s = tail_3;
        endcase
      end
      punc = !rm_repeat && e[17];
      if (!rm_repeat) e = punc ? (e + {1'b0, rm_ep} - {1'b0, rm_em}) : (e - {1'b0, rm_em});
      if (!punc) begin
        d[19 - 5*m_ptr -: 5] = s;
        be[3 - m_ptr] = 1'b1;
        exp_len++;
        if (m_ptr == 3) begin
          exp_q.push_back({m_word, d, be});
          d = '0;
          be = '0;
          m_word++;
          m_ptr = 0;
        end else begin
          m_ptr++;
        end
      end
    end
    if (be != 4'd0) exp_q.push_back({m_word, d, be});
  endtask

  task automatic do_init;
    @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    m_word = base_addr[17:2];
    m_ptr = int'(base_addr[1:0]);
  endtask

  task automatic pulse_start;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
  endtask

  task automatic run_block(output bit seen, output int exp_len);
    model_block(exp_len);
    pulse_start();
    wait_done(seen);
  endtask

  task automatic set_pass(input logic [17:0] base);
    base_addr = base;
    codeblk_size_m1 = 13'd7;
    rm_repeat = 1'b1;
    rm_ei = '0; rm_em = '0; rm_ep = '0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_assert++;
    if ({done, bus.siram_rd_req, bus.dwram_wr_req} !== 3'b000) begin
      n_fail++; $display("FAIL reset_strobes: got %b, expected 000", {done, bus.siram_rd_req, bus.dwram_wr_req});
    end
    n_assert++;
    if (rm_out_len !== 14'd0) begin
      n_fail++; $display("FAIL reset_out_len: got %0d, expected 0", rm_out_len);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_assert++;
    if (bus.siram_rd_addr !== 11'd0) begin
      n_fail++; $display("FAIL reset_rd_addr: got %h, expected 0", bus.siram_rd_addr);
    end
    n_assert++;
    if ({bus.dwram_wr_addr, bus.dwram_wr_data, bus.dwram_wr_be} !== 40'd0) begin
      n_fail++; $display("FAIL reset_wr_bus: got %h, expected 0", {bus.dwram_wr_addr, bus.dwram_wr_data, bus.dwram_wr_be});
    end
  endtask

  task automatic test_passthrough;
    bit seen;
    int exp_len;
    set_pass(18'h0);
    do_init();
    wr_log.delete();
    run_block(seen, exp_len);
    n_assert++;
    if (!seen) begin n_fail++; $display("FAIL pass_done: got no done, expected done"); end
    n_assert++;
    if (rm_out_len !== 14'd12) begin n_fail++; $display("FAIL pass_out_len: got %0d, expected 12", rm_out_len); end
    n_assert++;
    if (wr_log.size() != 3) begin n_fail++; $display("FAIL pass_nwrites: got %0d, expected 3", wr_log.size()); end
    n_assert++;
    if (wr_log.size() < 1 || wr_log[0] !== {16'd0, 5'd1, 5'd2, 5'd3, 5'd4, 4'hF}) begin
      n_fail++; $display("FAIL pass_word0: got %h, expected %h", (wr_log.size() > 0) ? wr_log[0] : 40'd0, {16'd0, 5'd1, 5'd2, 5'd3, 5'd4, 4'hF});
    end
    @(negedge clk);
    n_assert++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL pass_done_pulse: got %b one cycle later, expected 0", done); end
    n_assert++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL pass_missing: %0d writes outstanding, expected 0", exp_q.size()); end
  endtask

  task automatic test_puncture_back_to_back;
    bit seen;
    int exp_len;
    logic [39:0] first2;
    base_addr = '0;
    codeblk_size_m1 = 13'd7;
    rm_repeat = 1'b0;
    rm_ei = 17'd1; rm_em = 17'd1; rm_ep = 17'd2;
    do_init();
    wr_log.delete();
    run_block(seen, exp_len);
    n_assert++;
    if (!seen || rm_out_len !== 14'd6) begin
      n_fail++; $display("FAIL punc_out_len: got done=%b len=%0d, expected done=1 len=6", seen, rm_out_len);
    end
    n_assert++;
    if (wr_log.size() != 2 || wr_log[1] !== {16'd1, 5'h1C, 5'h1E, 10'd0, 4'b1100}) begin
      n_fail++; $display("FAIL punc_partial: got %0d writes last=%h, expected 2 writes last=%h",
                         wr_log.size(), (wr_log.size() > 1) ? wr_log[1] : 40'd0, {16'd1, 5'h1C, 5'h1E, 10'd0, 4'b1100});
    end
    run_block(seen, exp_len);
`ifdef TDEC_RM_CB_REBASE_EN
    first2 = {16'd0, 5'd1, 5'd3, 5'd5, 5'd7, 4'hF};
`else
    first2 = {16'd1, 10'd0, 5'd1, 5'd3, 4'b0011};
`endif
    n_assert++;
    if (wr_log.size() < 3 || wr_log[2] !== first2) begin
      n_fail++; $display("FAIL b2b_first_write: got %h, expected %h", (wr_log.size() > 2) ? wr_log[2] : 40'd0, first2);
    end
    n_assert++;
    if (!seen || rm_out_len !== 14'(exp_len) || exp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_block2: got done=%b len=%0d pending=%0d, expected done=1 len=%0d pending=0",
                         seen, rm_out_len, exp_q.size(), exp_len);
    end
  endtask

  task automatic test_offset;
    bit seen;
    int exp_len;
    set_pass(18'h6);
    do_init();
    wr_log.delete();
    run_block(seen, exp_len);
    n_assert++;
    if (wr_log.size() < 1 || wr_log[0] !== {16'd1, 10'd0, 5'd1, 5'd2, 4'b0011}) begin
      n_fail++; $display("FAIL offset_first: got %h, expected %h", (wr_log.size() > 0) ? wr_log[0] : 40'd0, {16'd1, 10'd0, 5'd1, 5'd2, 4'b0011});
    end
    n_assert++;
    if (wr_log.size() != 4 || wr_log[3] !== {16'd4, 5'h1E, 5'h1F, 10'd0, 4'b1100}) begin
      n_fail++; $display("FAIL offset_last: got %0d writes, expected 4 ending %h", wr_log.size(), {16'd4, 5'h1E, 5'h1F, 10'd0, 4'b1100});
    end
    n_assert++;
    if (!seen || rm_out_len !== 14'd12 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL offset_end: got done=%b len=%0d pending=%0d, expected 1/12/0", seen, rm_out_len, exp_q.size());
    end
  endtask

  task automatic test_ack_delay;
    bit seen;
    int exp_len;
    set_pass(18'h0);
    do_init();
    ack_delay = 3;
    req_hi_cycles = 0;
    wr_log.delete();
    run_block(seen, exp_len);
    ack_delay = 0;
    n_assert++;
    if (req_hi_cycles != 8) begin
      n_fail++; $display("FAIL ack_delay_req_hold: got %0d req-high cycles, expected 8", req_hi_cycles);
    end
    n_assert++;
    if (!seen || rm_out_len !== 14'd12 || exp_q.size() != 0 || wr_log.size() != 3) begin
      n_fail++; $display("FAIL ack_delay_result: got done=%b len=%0d pending=%0d writes=%0d, expected 1/12/0/3",
                         seen, rm_out_len, exp_q.size(), wr_log.size());
    end
  endtask

  task automatic test_init_abort;
    bit seen;
    int exp_len;
    int ndone;
    set_pass(18'h0);
    do_init();
    exp_q.push_back({16'd0, 5'd1, 5'd2, 5'd3, 5'd4, 4'hF});
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.dwram_wr_req) seen = 1'b1;
    end
    n_assert++;
    if (!seen) begin n_fail++; $display("FAIL abort_first_write: got no write, expected one"); end
    repeat (2) @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    n_assert++;
    if (bus.siram_rd_req !== 1'b0) begin n_fail++; $display("FAIL abort_req_drop: got %b, expected 0", bus.siram_rd_req); end
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    n_assert++;
    if (ndone != 0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL abort_quiet: got %0d done pulses pending=%0d, expected 0/0", ndone, exp_q.size());
    end
    m_word = '0;
    m_ptr = 0;
    run_block(seen, exp_len);
    n_assert++;
    if (!seen || rm_out_len !== 14'd12 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL abort_rerun: got done=%b len=%0d pending=%0d, expected 1/12/0", seen, rm_out_len, exp_q.size());
    end
  endtask

  task automatic test_all_punctured;
    bit seen;
    int exp_len;
    codeblk_size_m1 = 13'd9;
    rm_repeat = 1'b0;
    rm_ei = 17'd0; rm_em = 17'd1; rm_ep = 17'd1;
    wr_log.delete();
    run_block(seen, exp_len);
    repeat (3) @(negedge clk);
    n_assert++;
    if (!seen || rm_out_len !== 14'd0 || wr_log.size() != 0) begin
      n_fail++; $display("FAIL all_punc: got done=%b len=%0d writes=%0d, expected 1/0/0", seen, rm_out_len, wr_log.size());
    end
  endtask

  task automatic test_start_ignored;
    bit seen;
    int exp_len;
    int ndone;
    set_pass(18'h0);
    codeblk_size_m1 = 13'd10;
    model_block(exp_len);
    pulse_start();
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(seen);
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) ndone++;
    end
    n_assert++;
    if (!seen || ndone != 0 || rm_out_len !== 14'(exp_len) || exp_q.size() != 0) begin
      n_fail++; $display("FAIL start_ignored: got done=%b extra=%0d len=%0d pending=%0d, expected 1/0/%0d/0",
                         seen, ndone, rm_out_len, exp_q.size(), exp_len);
    end
  endtask

  task automatic test_random_blocks;
    bit seen;
    int exp_len;
    for (int k = 0; k < 8; k++) begin
      codeblk_size_m1 = (k == 0) ? 13'd0 : 13'($urandom_range(1, 40));
      rm_repeat = 1'($urandom_range(0, 1));
      rm_ei = 17'($urandom_range(0, 20));
      rm_em = 17'($urandom_range(1, 8));
      rm_ep = 17'($urandom_range(1, 16));
      if (k == 4) begin
        base_addr = 18'($urandom_range(0, 50));
        do_init();
      end
      run_block(seen, exp_len);
      n_assert++;
      if (!seen || rm_out_len !== 14'(exp_len) || exp_q.size() != 0) begin
        n_fail++; $display("FAIL random_block_%0d: got done=%b len=%0d pending=%0d, expected 1/%0d/0",
                           k, seen, rm_out_len, exp_q.size(), exp_len);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8200; i++) sym[i] = 5'(i + 1);
    test_reset();
    test_passthrough();
    test_puncture_back_to_back();
    test_offset();
    test_ack_delay();
    test_init_abort();
    test_all_punctured();
    test_start_ignored();
    test_random_blocks();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
